vidin_burst_writer: RTL



---
 rtl/vidin_burst_writer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/vidin_burst_writer.sv
// rtl/vidin_burst_writer.sv - packs a 16-bit pixel stream into 16-word SDRAM write bursts
// Two 16-word halves ping-pong between the capture fill side and the vidin drain FSM.
module vidin_burst_writer (
  input  logic        clk_96,
  input  logic        reset_n,
  input  logic        pix_en,
  input  logic [15:0] pix_d,
  input  logic        line_start,
  input  logic        frame_start,
  output logic        vidin_req,
  output logic        vidin_frame,
  output logic [9:0]  vidin_row,
  output logic [9:0]  vidin_col,
  output logic [15:0] vidin_d,
  input  logic        vidin_ack,
  output logic        overflow
);

  typedef enum logic {IDLE, BURST} drain_state_t;

  logic [15:0]  mem [0:31];
  logic [1:0]   full;
  logic [1:0]   tag_frame;
  logic [9:0]   tag_row [2];
  logic [9:0]   tag_col [2];

  logic         wr_half;
  logic [4:0]   wr_idx;
  logic         rd_half;
  logic [3:0]   rd_idx;
  logic         frame;
  logic [9:0]   row;
  logic [9:0]   col;
  drain_state_t state;

  logic         auto_commit;
  logic         flush;
  logic         commit_do;
  logic         flush_drop;
  logic         half_after;
  logic [4:0]   idx_after;
  logic         pix_ok;
  logic         pix_drop;
  logic         drain_done;
  logic [9:0]   row_next;
  logic [9:0]   col_next;
  logic [1:0]   full_next;

  // A completed half (wr_idx == 16) commits on the following edge; the event
  // order within a cycle is commit/frame_start, then line_start, then pixel.
  always_comb begin
    auto_commit = (wr_idx == 5'd16);
    flush       = line_start && !frame_start && (wr_idx != 5'd0) && !auto_commit;
    commit_do   = (auto_commit || flush) && !full[wr_half];
    flush_drop  = flush && full[wr_half];
    half_after  = commit_do ? ~wr_half : wr_half;
    idx_after   = (frame_start || auto_commit || flush) ? 5'd0 : wr_idx;
    pix_ok      = pix_en && !full[half_after];
    pix_drop    = pix_en && full[half_after];
    drain_done  = (state == BURST) && vidin_ack && (rd_idx == 4'd15);

    if (frame_start || line_start)
      col_next = 10'd0;
    else if (commit_do)
      col_next = col + 10'd1;
    else
      col_next = col;

    if (frame_start)
      row_next = line_start ? 10'd0 : 10'h3FF;
    else if (line_start)
      row_next = row + 10'd1;
    else
      row_next = row;

    full_next = full;
    if (drain_done)
      full_next[rd_half] = 1'b0;
    if (commit_do)
      full_next[wr_half] = 1'b1;
  end

  always_ff @(posedge clk_96) begin
    if (flush && commit_do) begin
      for (int i = 0; i < 16; i++) begin
        if (5'(i) >= wr_idx)
          mem[{wr_half, 4'(i)}] <= 16'h0000;
      end
    end
    if (pix_ok)
      mem[{half_after, idx_after[3:0]}] <= pix_d;
  end

  always_ff @(posedge clk_96 or negedge reset_n) begin
    if (!reset_n) begin
      full       <= 2'b00;
      tag_frame  <= 2'b00;
      tag_row[0] <= 10'd0;
      tag_row[1] <= 10'd0;
      tag_col[0] <= 10'd0;
      tag_col[1] <= 10'd0;
      wr_half    <= 1'b0;
      wr_idx     <= 5'd0;
      frame      <= 1'b0;
      row        <= 10'h3FF;
      col        <= 10'd0;
      overflow   <= 1'b0;
    end else begin
      full     <= full_next;
      wr_half  <= half_after;
      wr_idx   <= idx_after + {4'd0, pix_ok};
      frame    <= frame ^ frame_start;
      row      <= row_next;
      col      <= col_next;
      overflow <= (overflow && !frame_start) || pix_drop || flush_drop;
      if (commit_do) begin
        tag_frame[wr_half] <= frame;
        tag_row[wr_half]   <= row;
        tag_col[wr_half]   <= col;
      end
    end
  end

  // The IDLE pass guarantees at least one low cycle of vidin_req between bursts.
  always_ff @(posedge clk_96 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      vidin_req <= 1'b0;
      rd_half   <= 1'b0;
      rd_idx    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          rd_idx <= 4'd0;
          if (full[rd_half]) begin
            state     <= BURST;
            vidin_req <= 1'b1;
          end
        end
        BURST: begin
          if (vidin_ack) begin
            if (rd_idx == 4'd15) begin
              state     <= IDLE;
              vidin_req <= 1'b0;
              rd_half   <= ~rd_half;
              rd_idx    <= 4'd0;
            end else begin
              rd_idx <= rd_idx + 4'd1;
            end
          end
        end
      endcase
    end
  end

  assign vidin_d     = mem[{rd_half, rd_idx}];
  assign vidin_frame = tag_frame[rd_half];
  assign vidin_row   = tag_row[rd_half];
  assign vidin_col   = tag_col[rd_half];

endmodule
